uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter (8 data bits, no parity, LSB first, 1 or 2 stop bits). It is the stream sink at the read side of the peripheral TX FIFO: it consumes bytes over the same valid/ready stream handshake and serialises each one onto the tx line. The baud rate comes from a runtime divisor held in the UART control register.

Parameters:
DIVW, 16, width of the baud divisor input
STOP_BITS, 1, number of stop bits per frame; legal values are 1 and 2

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
tx_div  input  DIVW  baud divisor; bit period = tx_div+1 clk cycles
din  input  8  byte to transmit (stream data, Wishbone DAT_I)
din_vld  input  1  byte valid (STB_I)
din_rdy  output  1  byte accepted this cycle (ACK_O)
tx  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset values: tx=1, busy=0, state=IDLE, counters=0. din_rdy is 0 while rst=1.
- Handshake:
  - din_rdy = (state==IDLE) & ~rst, driven combinationally from the state register.
  - A byte transfers on the clk edge where din_vld & din_rdy; din is sampled into the shift register on that edge.
  - din_vld held with din_rdy=0 causes no side effects.
- tx_div is latched on the accept edge. Changes to tx_div mid-frame are ignored until the next accept.
- tx is a registered output, so the start bit appears on the cycle after the accept edge.
- State machine:
  - IDLE: tx=1, busy=0. On accept -> START.
  - START: tx=0 for tx_div+1 cycles -> DATA.
  - DATA: tx=shift[0] for tx_div+1 cycles per bit, shifting right at each bit end. After 8 bits -> STOP.
  - STOP: tx=1 for STOP_BITS*(tx_div+1) cycles -> IDLE.
- busy=1 in START, DATA and STOP.
- Baud counter:
  - DIVW-bit down-counter, loaded with the latched divisor at every bit start.
  - The bit ends on the cycle where count==0.
  - tx_div=0 gives 1-cycle bits. tx_div=all-ones gives 2^DIVW-cycle bits with no overflow.
- Bit counter: 3 bits, wraps 7->0 at the end of DATA. Stop-bit counter: 1 bit.
- Frame length: (9+STOP_BITS)*(tx_div+1) cycles of non-idle-state time.
- Back-to-back frames: the FIFO keeps din_vld high, so the next accept happens in the first IDLE cycle. Consecutive start-bit falling edges are therefore exactly (9+STOP_BITS)*(tx_div+1)+1 cycles apart; the extra cycle extends the stop bit.
- Reset mid-frame: on the next edge tx=1, busy=0, state=IDLE. The in-flight byte is discarded, with no partial re-send.
- Reset asserted together with din_vld: no accept happens, because din_rdy is gated by rst.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - localparam DATA_BITS=8.
- The package is shared with the future uart_rx.
- One sub-module, uart_baud_cnt: a loadable down-counter with a bit_end strobe (inputs clk, rst, load, div; output bit_end). uart_rx will reuse it.

Test Plan:
- Reset idle: rst high 3 cycles, then low with din_vld=0 -> tx=1, busy=0 and din_rdy=1 for 50 cycles.
- Single byte: tx_div=3, STOP_BITS=1, send 0xA5.
  - din_rdy pulses exactly 1 cycle and tx goes low the next cycle.
  - Sampled every 4 cycles, tx shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - busy stays high for 40 cycles.
- Back-to-back: tx_div=1, stream 0x00,0xFF,0x55 with din_vld held high -> start-bit falling edges exactly 21 cycles apart; a scoreboard decodes the same 3 bytes.
- Divisor latch and extremes:
  - tx_div=0: 0x3C decodes correctly with 1-cycle bits.
  - Change tx_div 2->7 mid-frame: the current frame keeps a 3-cycle bit period and the next frame uses 8 cycles.
- Reset mid-frame: tx_div=4, assert rst during data bit 3 -> tx=1 and busy=0 on the next edge. After release, 0x81 transmits cleanly with no leftover bits.
- STOP_BITS=2: tx_div=2, send 0x12 -> the stop phase lasts 6 cycles and busy is high for 33 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states and frame geometry.
// Also intended for use by uart_rx.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter. bit_end is high while the count sits at zero.
// A load on the bit_end cycle starts the next bit with no gap.
module uart_baud_cnt #(
   parameter int unsigned DIVW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [DIVW-1:0] div,
   output logic            bit_end
);

   logic [DIVW-1:0] count_q, count_d;

   // Holding at zero keeps an all-ones divisor from ever wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = div;
      end else if (count_q != '0) begin
         count_d = count_q - DIVW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bit_end = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 frames, LSB first, stream sink on the TX FIFO read side.
// The divisor is captured on each accept so a frame never changes speed mid-flight.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DIVW      = 16,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DIVW-1:0] tx_div,
   input  logic [7:0]      din,
   input  logic            din_vld,
   output logic            din_rdy,
   output logic            tx,
   output logic            busy
);

   tx_state_t                state_q, state_d;
   logic [DATA_BITS-1:0]     shift_q, shift_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic                     stop_cnt_q, stop_cnt_d;
   logic [DIVW-1:0]          div_q, div_d;
   logic                     tx_q, tx_d;
   logic                     accept;
   logic                     bit_end;
   logic                     load;
   logic [DIVW-1:0]          cnt_div;

   assign din_rdy = (state_q == IDLE) & ~rst;
   assign accept  = din_vld & din_rdy;
   assign busy    = (state_q != IDLE);
   assign tx      = tx_q;

   // The accept edge must load the live divisor; div_q is not valid until after it.
   assign load    = accept | (busy & bit_end);
   assign cnt_div = accept ? tx_div : div_q;

   uart_baud_cnt #(
      .DIVW(DIVW)
   ) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .div     (cnt_div),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      div_d      = div_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               shift_d = din;
               div_d   = tx_div;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (STOP_BITS == 2 && stop_cnt_q == 1'b0) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // tx is registered, so it is derived from the state being entered.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         div_q      <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         div_q      <= div_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one-stop-bit instance plus a two-stop-bit instance.
// Sent bytes go into a scoreboard queue and are compared against bytes decoded from tx.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tx_div, tx_div2;
   logic [7:0]  din, din2;
   logic        din_vld, din_vld2;
   logic        din_rdy, din_rdy2;
   logic        tx, tx2;
   logic        busy, busy2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [7:0] sb_q[$];

   uart_tx #(.DIVW(16), .STOP_BITS(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_div  (tx_div),
      .din     (din),
      .din_vld (din_vld),
      .din_rdy (din_rdy),
      .tx      (tx),
      .busy    (busy)
   );

   uart_tx #(.DIVW(16), .STOP_BITS(2)) dut2 (
      .clk     (clk),
      .rst     (rst),
      .tx_div  (tx_div2),
      .din     (din2),
      .din_vld (din_vld2),
      .din_rdy (din_rdy2),
      .tx      (tx2),
      .busy    (busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a byte on dut and wait (bounded) for its accept edge.
   task automatic drive_byte(input logic [7:0] b, input bit keep);
      int n = 0;
      din     = b;
      din_vld = 1'b1;
      sb_q.push_back(b);
      while (din_rdy !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (din_rdy !== 1'b1) begin
         failures++;
         $display("FAIL drive_accept: din_rdy=%b required 1", din_rdy);
      end
      @(negedge clk);
      if (!keep) din_vld = 1'b0;
   endtask

   // Decode one frame from dut.tx assuming bit period d+1; returns start-bit low run length.
   task automatic rx_frame(input int d, output logic [7:0] b, output int t_fall,
                           output int run, output bit ok);
      int n = 0;
      int total;
      bit inrun;
      logic t;
      ok = 1'b1;
      b = '0;
      run = 0;
      t_fall = 0;
      t = tx;
      while (t !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
         t = tx;
      end
      if (t !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      t_fall = cyc;
      inrun  = 1'b1;
      total  = 9 * (d + 1) + d / 2;
      for (int off = 0; off <= total; off++) begin
         if (off > 0) @(negedge clk);
         t = tx;
         if (inrun && t === 1'b0) run++;
         else inrun = 1'b0;
         if (off >= d + 1 && off < 9 * (d + 1) && ((off - (d + 1)) % (d + 1)) == d / 2)
            b[(off - (d + 1)) / (d + 1)] = t;
         if (off == total && t !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      int bad_tx = 0, bad_busy = 0, bad_rdy = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: tx=%b busy=%b din_rdy=%b required 1 0 0", tx, busy,
                     din_rdy);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (din_rdy !== 1'b1) bad_rdy++;
      end
      checks++;
      if (bad_tx != 0) begin
         failures++;
         $display("FAIL reset_idle_tx: %0d cycles not high, required 0", bad_tx);
      end
      checks++;
      if (bad_busy != 0) begin
         failures++;
         $display("FAIL reset_idle_busy: %0d cycles busy, required 0", bad_busy);
      end
      checks++;
      if (bad_rdy != 0) begin
         failures++;
         $display("FAIL reset_idle_rdy: %0d cycles not ready, required 0", bad_rdy);
      end
   endtask

   task automatic test_single_byte;
      logic [9:0] pat = 10'b1101001010;
      logic [9:0] seen = '0;
      logic [7:0] got, exp;
      int busy_cnt = 0;
      tx_div  = 16'd3;
      din     = 8'hA5;
      din_vld = 1'b1;
      checks++;
      if (din_rdy !== 1'b1) begin
         failures++;
         $display("FAIL single_rdy_high: din_rdy=%b required 1", din_rdy);
      end
      sb_q.push_back(8'hA5);
      @(negedge clk);
      din_vld = 1'b0;
      for (int off = 0; off < 60; off++) begin
         if (off > 0) @(negedge clk);
         if (off == 0) begin
            checks++;
            if (din_rdy !== 1'b0 || tx !== 1'b0) begin
               failures++;
               $display("FAIL single_rdy_pulse: din_rdy=%b tx=%b required 0 0", din_rdy, tx);
            end
         end
         if (busy === 1'b1) busy_cnt++;
         if (off < 40 && off % 4 == 0) seen[off / 4] = tx;
         if (off == 59) begin
            checks++;
            if (tx !== 1'b1) begin
               failures++;
               $display("FAIL single_idle_after: tx=%b required 1", tx);
            end
         end
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (seen[i] !== pat[i]) begin
            failures++;
            $display("FAIL single_bit%0d: tx=%b required %b", i, seen[i], pat[i]);
         end
      end
      got = seen[8:1];
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL single_decode: got 0x%02h required 0x%02h", got, exp);
      end
      checks++;
      if (busy_cnt != 40) begin
         failures++;
         $display("FAIL single_busy_len: %0d cycles required 40", busy_cnt);
      end
   endtask

   task automatic test_back_to_back;
      tx_div = 16'd1;
      fork
         begin
            drive_byte(8'h00, 1'b1);
            drive_byte(8'hFF, 1'b1);
            drive_byte(8'h55, 1'b0);
         end
         begin
            int prev = 0;
            for (int i = 0; i < 3; i++) begin
               logic [7:0] b, exp;
               int tf, run;
               bit ok;
               rx_frame(1, b, tf, run, ok);
               checks++;
               if (!ok) begin
                  failures++;
                  $display("FAIL b2b_frame%0d: framing ok=%b required 1", i, ok);
               end
               exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
               checks++;
               if (b !== exp) begin
                  failures++;
                  $display("FAIL b2b_decode%0d: got 0x%02h required 0x%02h", i, b, exp);
               end
               if (i > 0) begin
                  checks++;
                  if (tf - prev != 21) begin
                     failures++;
                     $display("FAIL b2b_spacing%0d: %0d cycles required 21", i, tf - prev);
                  end
               end
               prev = tf;
            end
         end
      join
   endtask

   task automatic test_div_zero;
      tx_div = 16'd0;
      fork
         drive_byte(8'h3C, 1'b0);
         begin
            logic [7:0] b, exp;
            int tf, run;
            bit ok;
            rx_frame(0, b, tf, run, ok);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || b !== exp) begin
               failures++;
               $display("FAIL div0_decode: got 0x%02h ok=%b required 0x%02h ok=1", b, ok, exp);
            end
         end
      join
   endtask

   task automatic test_div_change;
      tx_div = 16'd2;
      fork
         begin
            drive_byte(8'h97, 1'b0);
            repeat (10) @(negedge clk);
            tx_div = 16'd7;
            drive_byte(8'h69, 1'b0);
         end
         begin
            logic [7:0] b, exp;
            int tf, run;
            bit ok;
            rx_frame(2, b, tf, run, ok);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || b !== exp) begin
               failures++;
               $display("FAIL divchg_decode1: got 0x%02h ok=%b required 0x%02h ok=1", b, ok,
                        exp);
            end
            checks++;
            if (run != 3) begin
               failures++;
               $display("FAIL divchg_period1: start bit %0d cycles required 3", run);
            end
            rx_frame(7, b, tf, run, ok);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || b !== exp) begin
               failures++;
               $display("FAIL divchg_decode2: got 0x%02h ok=%b required 0x%02h ok=1", b, ok,
                        exp);
            end
            checks++;
            if (run != 8) begin
               failures++;
               $display("FAIL divchg_period2: start bit %0d cycles required 8", run);
            end
         end
      join
   endtask

   task automatic test_reset_mid_frame;
      int lows = 0;
      tx_div  = 16'd4;
      din     = 8'h00;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
      repeat (22) @(negedge clk);
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_before: tx=%b busy=%b required 0 1", tx, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || din_rdy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_after: tx=%b busy=%b din_rdy=%b required 1 0 0", tx, busy,
                  din_rdy);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || din_rdy !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         failures++;
         $display("FAIL midrst_idle: %0d non-idle cycles required 0", lows);
      end
      fork
         drive_byte(8'h81, 1'b0);
         begin
            logic [7:0] b, exp;
            int tf, run;
            bit ok;
            rx_frame(4, b, tf, run, ok);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (!ok || b !== exp || run != 5) begin
               failures++;
               $display("FAIL midrst_resend: got 0x%02h ok=%b start=%0d required 0x%02h 1 5",
                        b, ok, run, exp);
            end
         end
      join
   endtask

   task automatic test_two_stop;
      logic [7:0] got = '0;
      logic [7:0] exp;
      int busy_cnt = 0;
      int stop_cnt = 0;
      tx_div2  = 16'd2;
      din2     = 8'h12;
      din_vld2 = 1'b1;
      checks++;
      if (din_rdy2 !== 1'b1) begin
         failures++;
         $display("FAIL stop2_rdy: din_rdy=%b required 1", din_rdy2);
      end
      sb_q.push_back(8'h12);
      @(negedge clk);
      din_vld2 = 1'b0;
      for (int off = 0; off < 60; off++) begin
         if (off > 0) @(negedge clk);
         if (busy2 === 1'b1) busy_cnt++;
         if (off >= 27 && off <= 32 && tx2 === 1'b1) stop_cnt++;
         if (off >= 3 && off < 27 && off % 3 == 1) got[(off - 3) / 3] = tx2;
         if (off == 26) begin
            checks++;
            if (tx2 !== 1'b0) begin
               failures++;
               $display("FAIL stop2_last_data: tx=%b required 0", tx2);
            end
         end
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL stop2_decode: got 0x%02h required 0x%02h", got, exp);
      end
      checks++;
      if (stop_cnt != 6) begin
         failures++;
         $display("FAIL stop2_stop_len: %0d cycles required 6", stop_cnt);
      end
      checks++;
      if (busy_cnt != 33) begin
         failures++;
         $display("FAIL stop2_busy_len: %0d cycles required 33", busy_cnt);
      end
   endtask

   initial begin
      rst      = 1'b1;
      tx_div   = '0;
      tx_div2  = '0;
      din      = '0;
      din2     = '0;
      din_vld  = 1'b0;
      din_vld2 = 1'b0;
      test_reset();
      test_single_byte();
      repeat (5) @(negedge clk);
      test_back_to_back();
      repeat (5) @(negedge clk);
      test_div_zero();
      repeat (5) @(negedge clk);
      test_div_change();
      repeat (5) @(negedge clk);
      test_reset_mid_frame();
      repeat (5) @(negedge clk);
      test_two_stop();
      repeat (5) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d bytes left required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
